// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg : shared stage indices, latency codes and hazard-cause encoding
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pipe_ctrl_pkg;

  localparam int STG_F = 0;
  localparam int STG_D = 1;
  localparam int STG_E = 2;
  localparam int STG_M = 3;
  localparam int STG_W = 4;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_FREEZE = 3'd1,
    CAUSE_JUMP   = 3'd2,
    CAUSE_HAZARD = 3'd3,
    CAUSE_IMISS  = 3'd4
  } cause_e;

  // Highest-priority source wins; lower ones are ignored that cycle.
  function automatic cause_e pick_cause(input logic frozen, input logic jump,
                                        input logic haz, input logic imiss);
    if (frozen)      return CAUSE_FREEZE;
    else if (jump)   return CAUSE_JUMP;
    else if (haz)    return CAUSE_HAZARD;
    else if (imiss)  return CAUSE_IMISS;
    else             return CAUSE_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_scoreboard : per-register forwarding-latency counters with two busy ports
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int LAT_W = 3,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             issue,
  input  logic [AW-1:0]    issue_rd,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rs1_busy,
  output logic             rs2_busy
);

  logic [LAT_W-1:0] sb_q [NREGS];
  logic [LAT_W-1:0] sb_d [NREGS];

  always_comb begin
    sb_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      sb_d[i] = sb_q[i];
      if (!hold && (sb_q[i] != '0)) begin
        sb_d[i] = sb_q[i] - LAT_W'(1);
      end
      // A new producer replaces whatever count was left on its rd.
      if (issue && (int'(issue_rd) == i)) begin
        sb_d[i] = issue_lat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  assign rs1_busy = (rs1 != '0) && (sb_q[rs1] != '0);
  assign rs2_busy = (rs2 != '0) && (sb_q[rs2] != '0);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_sb.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_sb : N-stage stall/bubble controller with latency scoreboard and perf counters
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pipe_ctrl_sb
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int DEC_IDX    = STG_D,
  parameter int EX_IDX     = STG_E,
  parameter int MEM_IDX    = STG_M,
  parameter int NREGS      = 32,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  decode_i_valid,
  input  logic [4:0]            decode_i_rs1,
  input  logic [4:0]            decode_i_rs2,
  input  logic                  decode_i_rs1_used,
  input  logic                  decode_i_rs2_used,
  input  logic [4:0]            decode_i_rd,
  input  logic                  decode_i_reg_wen,
  input  logic [LAT_W-1:0]      decode_i_lat,
  input  logic                  execute_i_need_jump,
  input  logic                  icache_i_ready,
  input  logic                  dcache_i_ready,
  output logic [NUM_STAGES-1:0] ctrl_o_stall,
  output logic [NUM_STAGES-1:0] ctrl_o_bubble,
  output logic [CNT_W-1:0]      ctrl_o_stall_cnt,
  output logic [CNT_W-1:0]      ctrl_o_flush_cnt,
  output logic [CNT_W-1:0]      ctrl_o_freeze_cnt
);

  localparam int RW     = 5;
  localparam int NCNT   = 3;
  localparam int C_STL  = 0;
  localparam int C_FLS  = 1;
  localparam int C_FRZ  = 2;

  logic   rs1_busy;
  logic   rs2_busy;
  logic   frozen;
  logic   haz;
  logic   issue;
  cause_e cause;

  assign frozen = !dcache_i_ready;
  assign haz    = decode_i_valid &
                  ((decode_i_rs1_used & rs1_busy) | (decode_i_rs2_used & rs2_busy));
  assign cause  = pick_cause(frozen, execute_i_need_jump, haz, !icache_i_ready);

  // Decode still advances on an icache miss, so only freeze/jump/hazard block issue.
  assign issue  = !frozen & !execute_i_need_jump & !haz & decode_i_valid &
                  decode_i_reg_wen & (decode_i_rd != '0);

  pipe_scoreboard #(
    .NREGS (NREGS),
    .LAT_W (LAT_W),
    .AW    (RW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .hold      (frozen),
    .issue     (issue),
    .issue_rd  (decode_i_rd),
    .issue_lat (decode_i_lat),
    .rs1       (decode_i_rs1),
    .rs2       (decode_i_rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  always_comb begin
    ctrl_o_stall  = '0;
    ctrl_o_bubble = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      unique case (cause)
        CAUSE_FREEZE: begin
          ctrl_o_stall[k]  = (k <= MEM_IDX);
          ctrl_o_bubble[k] = (k == MEM_IDX + 1);
        end
        CAUSE_JUMP: begin
          ctrl_o_bubble[k] = (k >= 1) && (k <= EX_IDX);
        end
        CAUSE_HAZARD: begin
          ctrl_o_stall[k]  = (k <= DEC_IDX);
          ctrl_o_bubble[k] = (k == DEC_IDX + 1);
        end
        CAUSE_IMISS: begin
          ctrl_o_stall[k]  = (k == 0);
          ctrl_o_bubble[k] = (k == 1);
        end
        default: begin
        end
      endcase
    end
    if (rst) begin
      ctrl_o_stall  = '0;
      ctrl_o_bubble = '1;
    end
  end

  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NCNT-1:0]  cnt_hit;

  assign cnt_hit[C_STL] = (cause == CAUSE_HAZARD);
  assign cnt_hit[C_FLS] = (cause == CAUSE_JUMP);
  assign cnt_hit[C_FRZ] = (cause == CAUSE_FREEZE);

  always_comb begin
    for (int c = 0; c < NCNT; c++) begin
      cnt_d[c] = cnt_q[c];
      if (cnt_hit[c] && (cnt_q[c] != '1)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCNT; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ctrl_o_stall_cnt  = cnt_q[C_STL];
  assign ctrl_o_flush_cnt  = cnt_q[C_FLS];
  assign ctrl_o_freeze_cnt = cnt_q[C_FRZ];

endmodule

`default_nettype wire

// File: doc/pipe_ctrl_sb.md
Name: pipe_ctrl_sb

Overview:
- Parametrised successor to the fixed 5-stage hazard controller of the RV64 in-order pipeline.
- Generates per-stage stall/bubble vectors for an N-stage pipeline from four sources, in priority order: data-cache freeze, execute-stage redirect, scoreboard data hazard, instruction-cache miss.
- Holds a per-register latency scoreboard, so results that forward late (loads, pipelined mul/div) stall dependents for exactly the required number of cycles.
- Keeps saturating performance counters for stalls, flushes and freezes.

Parameters:
- NUM_STAGES, 5, number of pipeline registers; index 0 = F (pc), 1 = D, 2 = E, 3 = M, 4 = W.
- DEC_IDX, 1, register read by decode.
- EX_IDX, 2, register read by execute (where branches resolve).
- MEM_IDX, 3, register read by memory; constraint 1 <= DEC_IDX < EX_IDX < MEM_IDX < NUM_STAGES.
- NREGS, 32, architectural registers; x0 is never busy.
- LAT_W, 3, width of a scoreboard latency counter.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- decode_i_valid  in  1  decode holds a real instruction
- decode_i_rs1  in  5  source register 1
- decode_i_rs2  in  5  source register 2
- decode_i_rs1_used  in  1  rs1 is actually read
- decode_i_rs2_used  in  1  rs2 is actually read
- decode_i_rd  in  5  destination register
- decode_i_reg_wen  in  1  instruction writes rd
- decode_i_lat  in  LAT_W  cycles until rd becomes forwardable; 0 = ALU, 1 = load
- execute_i_need_jump  in  1  redirect resolved in execute
- icache_i_ready  in  1  fetch data valid this cycle
- dcache_i_ready  in  1  memory stage completes this cycle
- ctrl_o_stall  out  NUM_STAGES  hold register k
- ctrl_o_bubble  out  NUM_STAGES  load NOP into register k
- ctrl_o_stall_cnt  out  CNT_W  data-hazard stall cycles
- ctrl_o_flush_cnt  out  CNT_W  redirects taken
- ctrl_o_freeze_cnt  out  CNT_W  dcache freeze cycles

Behaviour:
- Reset (asynchronous, active-high): scoreboard counters = 0, perf counters = 0. While rst is high: ctrl_o_stall = 0, ctrl_o_bubble = all ones.
- Stall/bubble outputs are combinational from the inputs and the registered scoreboard; they take effect at the next clk edge.
- Stall and bubble are never both 1 for the same index.
- Hazard: haz = decode_i_valid & ((rs1_used & rs1 != 0 & sb[rs1] != 0) | (rs2_used & rs2 != 0 & sb[rs2] != 0)).
- Priority 1, freeze (!dcache_i_ready):
  - stall[0..MEM_IDX] = 1.
  - bubble[MEM_IDX+1] = 1 if MEM_IDX+1 < NUM_STAGES.
  - Jump, hazard and icache inputs are ignored; the jumping instruction stays in E and is honoured on the first unfrozen cycle.
- Priority 2, jump: bubble[1..EX_IDX] = 1; stall = 0 (F loads the target pc).
- Priority 3, hazard: stall[0..DEC_IDX] = 1; bubble[DEC_IDX+1] = 1.
- Priority 4, !icache_i_ready: stall[0] = 1; bubble[1] = 1.
- Otherwise all stall and bubble bits are 0.
- Scoreboard: one LAT_W-bit counter per register.
  - Frozen cycle: every counter holds.
  - Unfrozen cycle: every nonzero counter decrements by 1.
  - Issue = unfrozen & !jump & !haz & decode_i_valid & reg_wen & rd != 0. On issue, sb[rd] <= decode_i_lat; this write overrides the decrement of the same entry.
  - Issue with lat 0 clears any stale count on rd.
  - Issue proceeds under !icache_i_ready, because decode still advances.
  - Counters never underflow.
- Perf counters saturate at all ones:
  - stall_cnt += 1 on each priority-3 cycle.
  - flush_cnt += 1 on each priority-2 cycle.
  - freeze_cnt += 1 on each priority-1 cycle.
- Simultaneous jump and hazard: jump wins; the dependent is flushed, so no stall is counted.
- Reset mid-freeze or mid-hazard: all state clears immediately, with no pending stall afterwards.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - Default stage index constants (STG_F, STG_D, STG_E, STG_M, STG_W).
  - Latency encodings LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3.
  - A priority-cause enum (NONE, FREEZE, JUMP, HAZARD, IMISS).
- Sub-module pipe_scoreboard (NREGS, LAT_W): counter array, issue write, decrement/hold, and two read ports that return busy flags for rs1/rs2.

Test Plan:
- Load-use: issue x5 with lat 1, next decode reads rs1 = x5 -> stall = 00011, bubble = 00100 for exactly 1 cycle, stall_cnt = 1; the following cycle is clean.
- Mul chain: issue x7 with lat 3, then a dependent reads x7 -> 3 consecutive stall cycles, stall_cnt = 3. A reader of x0 or of an unused rs2 = x7 -> no stall.
- Jump plus hazard in the same cycle -> bubble = 00110, stall = 0, flush_cnt = 1, stall_cnt = 0, sb unchanged by the flushed instruction.
- dcache_i_ready low for 4 cycles while a jump is pending and sb[x5] = 1 -> stall = 01111, bubble = 10000 for 4 cycles, sb[x5] stays 1, freeze_cnt = 4. Jump bubble = 00110 appears on the 5th cycle.
- icache_i_ready low with an independent decode -> stall = 00001, bubble = 00010, and sb[rd] is set by the issue.
- Assert rst mid-hazard (sb[x5] = 2) -> outputs immediately go to stall = 0, bubble = 11111; after release, a reader of x5 sees no stall and all counters read 0. Preload stall_cnt near all ones (CNT_W = 4) -> it saturates at 15.
